// File: rtl/score_keeper_if.sv
// score_keeper_if: bundles the hit-event inputs and the game-state outputs
// of the scoring stage.
//   master : drives start/hit_valid/hit_grade/song_done, observes results
//   slave  : the score_keeper itself
interface score_keeper_if;
  logic        start;
  logic        hit_valid;
  logic [1:0]  hit_grade;   // 10 perfect, 01 good, 00 miss, 11 reserved
  logic        song_done;
  logic [19:0] score;
  logic [9:0]  combo;
  logic [9:0]  max_combo;
  logic [2:0]  mult;
  logic [3:0]  health;
  logic        playing;
  logic        game_over;

  modport master (
    output start, hit_valid, hit_grade, song_done,
    input  score, combo, max_combo, mult, health, playing, game_over
  );

  modport slave (
    input  start, hit_valid, hit_grade, song_done,
    output score, combo, max_combo, mult, health, playing, game_over
  );
endinterface

// File: rtl/score_keeper.sv
// score_keeper: rhythm-game scoring stage. Runs the IDLE/PLAYING/OVER
// session FSM and keeps combo, multiplier, health and a saturating score
// for the six-digit display.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   sk    : score_keeper_if.slave (hit events in, game state out)
module score_keeper #(
  parameter int MAX_SCORE   = 999999,
  parameter int PERFECT_PTS = 100,
  parameter int GOOD_PTS    = 50,
  parameter int COMBO_STEP  = 10,
  parameter int MAX_MULT    = 4,
  parameter int MAX_HEALTH  = 8
) (
  input  logic           clk,
  input  logic           reset,
  score_keeper_if.slave  sk
);

  typedef enum logic [1:0] {IDLE, PLAYING, OVER} state_t;

  localparam logic [1:0] G_PERFECT = 2'b10;
  localparam logic [1:0] G_GOOD    = 2'b01;
  localparam logic [1:0] G_MISS    = 2'b00;

  state_t      state, state_n;
  logic [19:0] score, score_n;
  logic [9:0]  combo, combo_n;
  logic [9:0]  max_combo, max_combo_n;
  logic [2:0]  mult, mult_n;
  logic [3:0]  health, health_n;

  // Hit datapath, only consumed when a perfect/good hit is accepted.
  logic        is_perfect;
  logic [20:0] base, sum;
  logic [9:0]  combo_inc;
  logic [10:0] mult_raw;

  always_comb begin
    is_perfect = (sk.hit_grade == G_PERFECT);
    base       = is_perfect ? 21'(PERFECT_PTS) : 21'(GOOD_PTS);
    // Pre-hit multiplier; 21-bit sum so the clamp sees any overflow.
    sum        = {1'b0, score} + base * {18'd0, mult};
    combo_inc  = (combo == 10'd1023) ? combo : combo + 10'd1;
    mult_raw   = 11'(combo_inc / 10'(COMBO_STEP)) + 11'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      score     <= '0;
      combo     <= '0;
      max_combo <= '0;
      mult      <= 3'd1;
      health    <= '0;
    end else begin
      state     <= state_n;
      score     <= score_n;
      combo     <= combo_n;
      max_combo <= max_combo_n;
      mult      <= mult_n;
      health    <= health_n;
    end
  end

  always_comb begin
    state_n     = state;
    score_n     = score;
    combo_n     = combo;
    max_combo_n = max_combo;
    mult_n      = mult;
    health_n    = health;

    // A start in any state (re)loads a fresh game; hits that cycle are dropped.
    if (sk.start) begin
      state_n     = PLAYING;
      score_n     = '0;
      combo_n     = '0;
      max_combo_n = '0;
      mult_n      = 3'd1;
      health_n    = 4'(MAX_HEALTH);
    end else if (state == PLAYING) begin
      if (sk.hit_valid) begin
        if (sk.hit_grade == G_PERFECT || sk.hit_grade == G_GOOD) begin
          score_n     = (sum > 21'(MAX_SCORE)) ? 20'(MAX_SCORE) : sum[19:0];
          combo_n     = combo_inc;
          mult_n      = (mult_raw > 11'(MAX_MULT)) ? 3'(MAX_MULT) : mult_raw[2:0];
          max_combo_n = (combo_inc > max_combo) ? combo_inc : max_combo;
          if (is_perfect && health < 4'(MAX_HEALTH))
            health_n = health + 4'd1;
        end else if (sk.hit_grade == G_MISS) begin
          combo_n  = '0;
          mult_n   = 3'd1;
          health_n = (health != 4'd0) ? health - 4'd1 : health;
          if (health_n == 4'd0)
            state_n = OVER;
        end
      end
      // The hit above is still scored when the chart ends on the same edge.
      if (sk.song_done)
        state_n = OVER;
    end
  end

  assign sk.score     = score;
  assign sk.combo     = combo;
  assign sk.max_combo = max_combo;
  assign sk.mult      = mult;
  assign sk.health    = health;
  assign sk.playing   = (state == PLAYING);
  assign sk.game_over = (state == OVER);

endmodule
